ram_write_sequencer: RTL and testbench

//   Upstream write controller for the NBits x 2**NAddr board RAM. Debounces a write pushbutton and

---
 rtl/ram_write_sequencer.sv | 127 ++++++++++++
 tb/tb_ram_write_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_write_sequencer.sv
// ram_write_sequencer: debounced pushbutton write/clear sequencer for a small board RAM.
// Optional feature macro AUTO_SCAN_EN: when defined, the idle read address comes from an
// internal scan counter stepping every SCAN_DIV cycles instead of from rd_addr_in.
module ram_write_sequencer #(
  parameter int NBits     = 7,
  parameter int NAddr     = 3,
  parameter int DB_CYCLES = 500000,
  parameter int SCAN_DIV  = 25000000
) (
  input  logic             MAX10_CLK1_50,
  input  logic             rst,
  input  logic             key_wr_n,
  input  logic             key_clr_n,
  input  logic [NBits-1:0] data_in,
  input  logic [NAddr-1:0] rd_addr_in,
  output logic             ram_wr_en,
  output logic [NAddr-1:0] ram_addr,
  output logic [NBits-1:0] ram_data,
  output logic [NAddr-1:0] wr_ptr,
  output logic [NAddr:0]   count,
  output logic             full
);
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [NAddr:0] DEPTH = {1'b1, {NAddr{1'b0}}};

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  state_t           state, state_nxt;
  logic [1:0]       key_raw, press;
  logic             wr_press, clr_press, clr_pend, clr_now, go;
  logic [NAddr:0]   cnt_inc;
  logic [NAddr-1:0] rd_addr;

  assign key_raw   = {key_clr_n, key_wr_n};
  assign wr_press  = press[0];
  assign clr_press = press[1];

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic [1:0]     sync;
    logic [DBW-1:0] cnt;
    logic           db, db_d;
    // synchronize, then accept a new level only after DB_CYCLES consecutive differing cycles
    always_ff @(posedge MAX10_CLK1_50 or negedge rst)
      if (!rst) begin
        sync <= 2'b11;
        cnt  <= '0;
        db   <= 1'b1;
        db_d <= 1'b1;
      end else begin
        sync <= {sync[0], key_raw[k]};
        cnt  <= (sync[1] == db || cnt == DBW'(DB_CYCLES - 1)) ? '0 : cnt + 1'b1;
        db   <= (sync[1] != db && cnt == DBW'(DB_CYCLES - 1)) ? sync[1] : db;
        db_d <= db;
      end
    assign press[k] = db_d & ~db;
  end

`ifdef AUTO_SCAN_EN
  localparam int SDW = $clog2(SCAN_DIV + 1);
  logic [SDW-1:0]   div;
  logic [NAddr-1:0] scan;
  logic             step;
  assign step    = div == SDW'(SCAN_DIV - 1);
  assign rd_addr = scan;
  // free-running read scan, frozen while a write is in flight
  always_ff @(posedge MAX10_CLK1_50 or negedge rst)
    if (!rst) begin
      div  <= '0;
      scan <= '0;
    end else if (state == IDLE) begin
      div  <= step ? '0 : div + 1'b1;
      scan <= scan + NAddr'(step);
    end
`else
  assign rd_addr = rd_addr_in;
`endif

  // state register
  always_ff @(posedge MAX10_CLK1_50 or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;

  // next state; a clear (fresh or pending) in IDLE takes priority over a write press
  always_comb begin
    state_nxt = state;
    clr_now   = 1'b0;
    go        = 1'b0;
    case (state)
      IDLE: begin
        clr_now   = clr_press | clr_pend;
        go        = wr_press & ~full & ~clr_now;
        state_nxt = go ? WRITE : IDLE;
      end
      WRITE:   state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cnt_inc = full ? count : count + 1'b1;

  // registered RAM interface, pointer/count bookkeeping and deferred clear
  always_ff @(posedge MAX10_CLK1_50 or negedge rst)
    if (!rst) begin
      ram_wr_en <= 1'b1;
      ram_addr  <= '0;
      ram_data  <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      clr_pend  <= 1'b0;
    end else begin
      ram_wr_en <= state_nxt != WRITE;
      ram_addr  <= go ? wr_ptr : (state == IDLE ? rd_addr : ram_addr);
      ram_data  <= go ? data_in : ram_data;
      clr_pend  <= (state != IDLE) & (clr_pend | clr_press);
      if (clr_now) begin
        wr_ptr <= '0;
        count  <= '0;
        full   <= 1'b0;
      end else if (state == HOLD) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= cnt_inc;
        full   <= cnt_inc == DEPTH;
      end
    end
endmodule

// File: tb/tb_ram_write_sequencer.sv
// tb_ram_write_sequencer: randomized bench for ram_write_sequencer against a pointer/count model.
module tb_ram_write_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_wr_n = 1'b1;
  logic       key_clr_n = 1'b1;
  logic [6:0] data_in = '0;
  logic [2:0] rd_addr_in = '0;
  logic       ram_wr_en;
  logic [2:0] ram_addr;
  logic [6:0] ram_data;
  logic [2:0] wr_ptr;
  logic [3:0] count;
  logic       full;

  int total = 0;
  int bad = 0;
  int wr_log[$];
  int exp_q[$];
  int long_pulse = 0;
  logic prev_low = 1'b0;
  int m_ptr = 0;
  int m_cnt = 0;

  ram_write_sequencer #(.NBits(7), .NAddr(3), .DB_CYCLES(4), .SCAN_DIV(8)) dut (
    .MAX10_CLK1_50(clk), .rst(rst), .key_wr_n(key_wr_n), .key_clr_n(key_clr_n),
    .data_in(data_in), .rd_addr_in(rd_addr_in), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
    .ram_data(ram_data), .wr_ptr(wr_ptr), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && !ram_wr_en) begin
      wr_log.push_back(int'(ram_addr) * 256 + int'(ram_data));
      if (prev_low) long_pulse++;
    end
    prev_low <= rst && !ram_wr_en;
  end

  task automatic chk(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_wr(int d);
    if (m_cnt < 8) begin
      exp_q.push_back(m_ptr * 256 + d);
      m_ptr = (m_ptr + 1) % 8;
      m_cnt++;
    end
  endtask

  task automatic model_clr();
    m_ptr = 0;
    m_cnt = 0;
  endtask

  task automatic check_writes(string tag);
    chk({tag, "_nwr"}, wr_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
      chk({tag, "_addr"}, wr_log[i] / 256, exp_q[i] / 256);
      chk({tag, "_data"}, wr_log[i] % 256, exp_q[i] % 256);
    end
    wr_log.delete();
    exp_q.delete();
  endtask

  task automatic check_state(string tag);
    chk({tag, "_ptr"}, int'(wr_ptr), m_ptr);
    chk({tag, "_count"}, int'(count), m_cnt);
    chk({tag, "_full"}, int'(full), m_cnt == 8 ? 1 : 0);
  endtask

  task automatic press_wr(int d, int hold);
    data_in = 7'(d);
    key_wr_n = 1'b0;
    tick(hold);
    key_wr_n = 1'b1;
    tick(20);
    model_wr(d);
  endtask

  task automatic press_clr();
    key_clr_n = 1'b0;
    tick(10);
    key_clr_n = 1'b1;
    tick(20);
    model_clr();
  endtask

  task automatic bounce(int reps);
    repeat (reps) begin
      key_wr_n = 1'b0;
      tick(3);
      key_wr_n = 1'b1;
      tick(1);
    end
    tick(20);
  endtask

  task automatic clr_during_wr(int d, int off);
    data_in = 7'(d);
    key_wr_n = 1'b0;
    if (off > 0) tick(off);
    key_clr_n = 1'b0;
    tick(12);
    key_wr_n = 1'b1;
    key_clr_n = 1'b1;
    tick(20);
    if (off > 0) model_wr(d);
    model_clr();
  endtask

  initial begin
    bit seen;
    int a;
    tick(3);
    chk("rst_we", int'(ram_wr_en), 1);
    chk("rst_addr", int'(ram_addr), 0);
    chk("rst_data", int'(ram_data), 0);
    check_state("rst");
    rst = 1'b1;
    tick(5);

    press_wr(8'h55, 10);
    check_writes("single");
    check_state("single");

    bounce(6);
    check_writes("bounce");
    check_state("bounce");
    press_wr(8'h2a, 100);
    check_writes("long_hold");
    check_state("long_hold");

    data_in = 7'h33;
    key_wr_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1);
      seen = !ram_wr_en;
    end
    chk("wait_we_low", int'(seen), 1);
    rst = 1'b0;
    #1;
    chk("midrst_we", int'(ram_wr_en), 1);
    chk("midrst_data", int'(ram_data), 0);
    model_clr();
    check_state("midrst");
    key_wr_n = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(20);
    wr_log.delete();
    exp_q.delete();
    check_state("after_rst");

    for (int i = 1; i <= 8; i++) press_wr(i, 10);
    check_writes("fill");
    check_state("fill");
    press_wr(8'h7f, 10);
    check_writes("ninth");
    check_state("ninth");

    press_clr();
    check_writes("clear");
    check_state("clear");

    for (int r = 0; r < 6; r++) begin
      press_wr(int'($urandom_range(0, 127)), 10);
      press_wr(int'($urandom_range(0, 127)), 10);
      clr_during_wr(int'($urandom_range(0, 127)), r % 4);
      check_writes("clr_wr");
      check_state("clr_wr");
    end

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        4: bounce(int'($urandom_range(1, 5)));
        5: press_clr();
        default: press_wr(int'($urandom_range(0, 127)), int'($urandom_range(10, 30)));
      endcase
      check_writes("rand");
      check_state("rand");
    end

`ifdef AUTO_SCAN_EN
    for (int i = 0; i < 10; i++) begin
      a = int'(ram_addr);
      tick(8);
      chk("scan_step", int'(ram_addr), (a + 1) % 8);
    end
`else
    for (int i = 0; i < 6; i++) begin
      a = (i == 0) ? 5 : int'($urandom_range(0, 7));
      rd_addr_in = 3'(a);
      tick(1);
      chk("rd_addr", int'(ram_addr), a);
    end
`endif
    chk("pulse_width", long_pulse, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
